// File: rtl/sdi_pkg.sv
// Shared constants and FSM encoding for the SDI local packet framer.
// Flag bits sit below the data field in every buffer entry.
package sdi_pkg;

  localparam logic [7:0]  KSTART    = 8'h5C;
  localparam int          START_BIT = 1;
  localparam int          END_BIT   = 0;
  localparam logic [31:0] CRC_POLY  = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    LAST,
    CRC,
    PAD,
    DROP
  } fsm_e;

endpackage

// File: rtl/sdi_crc32_d32.sv
// One-word step of CRC-32 (poly 04C11DB7), MSB first, no reflection.
// Purely combinational; the framer registers the result.
module sdi_crc32_d32
  import sdi_pkg::*;
(
  input  logic [31:0] Crc,
  input  logic [31:0] Data,
  output logic [31:0] CrcNext
);

  logic [31:0] c;

  always_comb begin
    c = Crc;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ Data[i]) c = {c[30:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[30:0], 1'b0};
    end
    CrcNext = c;
  end

endmodule

// File: rtl/sdi_local_packet_framer.sv
// Frames local BPM words into SDI packets inside a store-and-forward
// buffer; packets become readable only once fully written.
module sdi_local_packet_framer #(
  parameter int         DATA_W = 32,
  parameter int         SIZE_W = 12,
  parameter int         DEST_W = 12,
  parameter int         ADDR_W = 9,
  parameter int         NPAD   = 2,
  parameter logic [7:0] KSTART = sdi_pkg::KSTART
) (
  input  logic              FillClock,
  input  logic              Reset,
  input  logic [SIZE_W-1:0] SourcePacketSizeIn,
  input  logic [DEST_W-1:0] SourcePacketDestIn,
  input  logic [DATA_W-1:0] DataIn,
  input  logic              DataInValid,
  output logic              DataInReady,
  output logic [DATA_W+1:0] DataOut,
  input  logic              FlushEnable,
  output logic              BufferEmpty,
  output logic              PacketReady,
  output logic              PacketError,
  output logic [15:0]       PacketCount,
  output logic [15:0]       DropCount,
  output logic              full
);

  import sdi_pkg::*;

  localparam int DEPTH = 2**ADDR_W;
  localparam int EW    = DATA_W + 2;
  localparam int CW    = ((SIZE_W > ADDR_W) ? SIZE_W : ADDR_W) + 2;

  typedef logic [ADDR_W:0] ptr_t;

  fsm_e state, stateNext;

  logic [EW-1:0]     mem [DEPTH];
  ptr_t              wrPtr, rdPtr, commitPtr, used, readyCnt;
  logic [CW-1:0]     freeW, needW;
  logic [DATA_W-1:0] regWord, hdrData, crcData;
  logic [31:0]       crcReg, crcSeed, crcNext;
  logic [SIZE_W-1:0] remaining;
  logic [1:0]        padCnt;
  logic [EW-1:0]     wData;
  logic              accept, tooSmall, noRoom, lastPad;
  logic              we, crcEn, commit, reject, pop, popEnd;

  assign accept   = DataInValid && DataInReady;
  assign used     = wrPtr - rdPtr;
  assign freeW    = CW'(DEPTH) - CW'(used);
  assign needW    = CW'(SourcePacketSizeIn) + CW'(NPAD);
  assign tooSmall = SourcePacketSizeIn < SIZE_W'(3);
  assign noRoom   = needW > freeW;
  assign lastPad  = padCnt == 2'(NPAD - 1);
  assign hdrData  = {SourcePacketSizeIn, SourcePacketDestIn, KSTART};

  // Header seeds the CRC from INIT; later steps chain the running value.
  assign crcSeed = (state == IDLE) ? CRC_INIT : crcReg;
  assign crcData = (state == IDLE) ? hdrData : regWord;

  sdi_crc32_d32 uCrc (
    .Crc     (crcSeed),
    .Data    (crcData),
    .CrcNext (crcNext)
  );

  always_ff @(posedge FillClock or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext   = state;
    DataInReady = 1'b0;
    we          = 1'b0;
    wData       = '0;
    crcEn       = 1'b0;
    commit      = 1'b0;
    reject      = 1'b0;
    unique case (state)
      IDLE: begin
        DataInReady = !Reset;
        if (accept) begin
          if (tooSmall) begin
            reject = 1'b1;
          end else if (noRoom) begin
            reject = 1'b1;
            if (SourcePacketSizeIn > SIZE_W'(3)) stateNext = DROP;
          end else begin
            we                = 1'b1;
            wData             = {hdrData, 2'b00};
            wData[START_BIT]  = 1'b1;
            crcEn             = 1'b1;
            stateNext = (SourcePacketSizeIn == SIZE_W'(3)) ? LAST : DATA;
          end
        end
      end
      DATA: begin
        DataInReady = !Reset;
        if (accept) begin
          we    = 1'b1;
          wData = {regWord, 2'b00};
          crcEn = 1'b1;
          if (remaining == SIZE_W'(1)) stateNext = LAST;
        end
      end
      LAST: begin
        we        = 1'b1;
        wData     = {regWord, 2'b00};
        crcEn     = 1'b1;
        stateNext = CRC;
      end
      CRC: begin
        we             = 1'b1;
        wData          = {DATA_W'(crcReg), 2'b00};
        wData[END_BIT] = 1'b1;
        if (NPAD == 0) begin
          commit    = 1'b1;
          stateNext = IDLE;
        end else begin
          stateNext = PAD;
        end
      end
      PAD: begin
        we = 1'b1;
        if (lastPad) begin
          commit    = 1'b1;
          stateNext = IDLE;
        end
      end
      DROP: begin
        DataInReady = !Reset;
        if (accept && remaining == SIZE_W'(1)) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge FillClock) begin
    if (we) mem[wrPtr[ADDR_W-1:0]] <= wData;
  end

  assign DataOut     = mem[rdPtr[ADDR_W-1:0]];
  assign BufferEmpty = rdPtr == commitPtr;
  assign PacketReady = readyCnt != '0;
  assign full        = used[ADDR_W];
  assign pop         = FlushEnable && !BufferEmpty;
  assign popEnd      = pop && DataOut[END_BIT];

  always_ff @(posedge FillClock or posedge Reset) begin
    if (Reset) begin
      wrPtr       <= '0;
      rdPtr       <= '0;
      commitPtr   <= '0;
      readyCnt    <= '0;
      regWord     <= '0;
      crcReg      <= CRC_INIT;
      remaining   <= '0;
      padCnt      <= '0;
      PacketError <= 1'b0;
      PacketCount <= '0;
      DropCount   <= '0;
    end else begin
      PacketError <= reject;
      if (reject && DropCount != 16'hFFFF) DropCount <= DropCount + 16'd1;
      if (we) wrPtr <= wrPtr + ptr_t'(1);
      if (crcEn) crcReg <= crcNext;
      if (accept) begin
        regWord <= DataIn;
        if (state == IDLE) remaining <= SourcePacketSizeIn - SIZE_W'(3);
        else               remaining <= remaining - SIZE_W'(1);
      end
      padCnt <= (state == PAD) ? padCnt + 2'd1 : 2'd0;
      if (commit) begin
        commitPtr   <= wrPtr + ptr_t'(1);
        PacketCount <= PacketCount + 16'd1;
      end
      if (pop) rdPtr <= rdPtr + ptr_t'(1);
      // A commit and an end-word pop on one edge cancel out.
      if (commit && !popEnd)      readyCnt <= readyCnt + ptr_t'(1);
      else if (!commit && popEnd) readyCnt <= readyCnt - ptr_t'(1);
    end
  end

endmodule

// File: tb/tb_sdi_local_packet_framer.sv
// Scoreboard bench for sdi_local_packet_framer (16-entry buffer, 2 pads).
// Driver pushes expected entries; a monitor checks every popped word.
module tb_sdi_local_packet_framer;

  localparam int DW = 32;
  localparam int SW = 12;
  localparam int AW = 4;
  localparam int NP = 2;
  localparam int DEPTH = 16;

  logic          FillClock = 1'b0;
  logic          Reset;
  logic [SW-1:0] SourcePacketSizeIn;
  logic [11:0]   SourcePacketDestIn;
  logic [DW-1:0] DataIn;
  logic          DataInValid;
  logic          DataInReady;
  logic [DW+1:0] DataOut;
  logic          FlushEnable = 1'b0;
  logic          BufferEmpty;
  logic          PacketReady;
  logic          PacketError;
  logic [15:0]   PacketCount;
  logic [15:0]   DropCount;
  logic          full;

  sdi_local_packet_framer #(.ADDR_W(AW), .NPAD(NP)) dut (
    .FillClock          (FillClock),
    .Reset              (Reset),
    .SourcePacketSizeIn (SourcePacketSizeIn),
    .SourcePacketDestIn (SourcePacketDestIn),
    .DataIn             (DataIn),
    .DataInValid        (DataInValid),
    .DataInReady        (DataInReady),
    .DataOut            (DataOut),
    .FlushEnable        (FlushEnable),
    .BufferEmpty        (BufferEmpty),
    .PacketReady        (PacketReady),
    .PacketError        (PacketError),
    .PacketCount        (PacketCount),
    .DropCount          (DropCount),
    .full               (full)
  );

  always #5 FillClock = ~FillClock;

  logic [DW+1:0] expQ[$];
  int vecs = 0, errs = 0;
  int popCnt = 0, written = 0;
  int errSeen = 0, expErr = 0, expPkt = 0, expDrop = 0;
  int rdMode = 0;
  logic popSeen = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  // Word-wide CRC as (crc ^ word) * x^32 mod G.
  function automatic logic [31:0] crcStep(logic [31:0] c, logic [31:0] d);
    logic [63:0] v;
    logic [63:0] g;
    v = {c ^ d, 32'h0};
    g = {31'h0, 1'b1, 32'h04C11DB7};
    for (int i = 63; i >= 32; i--)
      if (v[i]) v = v ^ (g << (i - 32));
    return v[31:0];
  endfunction

  always @(posedge FillClock) begin
    #1;
    case (rdMode)
      1:       FlushEnable = 1'($urandom_range(1));
      2:       FlushEnable = 1'b1;
      default: FlushEnable = 1'b0;
    endcase
  end

  always @(negedge FillClock) begin
    logic [DW+1:0] e;
    popSeen = 1'b0;
    if (!Reset) begin
      if (PacketError) errSeen++;
      if (FlushEnable && !BufferEmpty) begin
        popSeen = 1'b1;
        chk("pop_has_expect", 64'(expQ.size() != 0), 64'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          chk("dataout", 64'(DataOut), 64'(e));
        end
      end
    end
  end

  always @(posedge FillClock) if (popSeen) popCnt++;

  task automatic sendPkt(input int s, input logic [11:0] dest,
                         input int gapPct, input int gapAt,
                         input int abortAfter);
    int n;
    int t;
    int occ;
    logic [31:0] w[$];
    logic [31:0] c;
    logic [31:0] hdr;
    n = (s >= 3) ? s - 2 : 1;
    for (int i = 0; i < n; i++) w.push_back($urandom);
    SourcePacketSizeIn = SW'(s);
    SourcePacketDestIn = dest;
    for (int i = 0; i < n; i++) begin
      if (i == gapAt || (i > 0 && $urandom_range(99) < gapPct)) begin
        DataInValid = 1'b0;
        repeat ((i == gapAt) ? 1 : $urandom_range(1, 3)) @(posedge FillClock);
        #1;
      end
      DataInValid = 1'b1;
      DataIn = w[i];
      t = 0;
      @(negedge FillClock);
      while (!DataInReady && t < 100) begin
        @(negedge FillClock);
        t++;
      end
      if (!DataInReady) begin
        chk("accept_timeout", 64'(DataInReady), 64'd1);
        @(posedge FillClock); #1;
        DataInValid = 1'b0;
        return;
      end
      if (i == 0) begin
        occ = written - popCnt;
        if (s < 3 || DEPTH - occ < s + NP) begin
          expErr++;
          if (expDrop < 65535) expDrop++;
        end else begin
          written += s + NP;
          expPkt++;
          hdr = {SW'(s), dest, 8'h5C};
          expQ.push_back({hdr, 2'b10});
          c = crcStep(32'hFFFFFFFF, hdr);
          foreach (w[k]) begin
            expQ.push_back({w[k], 2'b00});
            c = crcStep(c, w[k]);
          end
          expQ.push_back({c, 2'b01});
          for (int k = 0; k < NP; k++) expQ.push_back('0);
        end
      end
      @(posedge FillClock); #1;
      if (abortAfter == i + 1) begin
        DataInValid = 1'b0;
        return;
      end
    end
    DataInValid = 1'b0;
  endtask

  // Called right after the last payload accept (cycle L+1).
  task automatic commitTiming(input string nm);
    repeat (4) @(negedge FillClock);
    chk({nm, "_empty_L4"}, 64'(BufferEmpty), 64'd1);
    chk({nm, "_prdy_L4"}, 64'(PacketReady), 64'd0);
    @(negedge FillClock);
    chk({nm, "_empty_L5"}, 64'(BufferEmpty), 64'd0);
    chk({nm, "_prdy_L5"}, 64'(PacketReady), 64'd1);
    @(posedge FillClock); #1;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    @(negedge FillClock);
    rdMode = 2;
    @(negedge FillClock);
    while (!BufferEmpty && t < 300) begin
      @(negedge FillClock);
      t++;
    end
    rdMode = 0;
    chk({nm, "_empty"}, 64'(BufferEmpty), 64'd1);
    chk({nm, "_qleft"}, 64'(expQ.size()), 64'd0);
    chk({nm, "_prdy"}, 64'(PacketReady), 64'd0);
    @(posedge FillClock); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    DataInValid = 1'b0;
    DataIn = '0;
    SourcePacketSizeIn = '0;
    SourcePacketDestIn = '0;
    repeat (3) @(posedge FillClock);
    @(negedge FillClock);
    chk("rst_ready", 64'(DataInReady), 64'd0);
    chk("rst_empty", 64'(BufferEmpty), 64'd1);
    chk("rst_prdy", 64'(PacketReady), 64'd0);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_err", 64'(PacketError), 64'd0);
    chk("rst_pcnt", 64'(PacketCount), 64'd0);
    chk("rst_dcnt", 64'(DropCount), 64'd0);
    @(posedge FillClock); #1;
    Reset = 1'b0;
    @(negedge FillClock);
    chk("idle_ready", 64'(DataInReady), 64'd1);
    @(posedge FillClock); #1;

    sendPkt(5, 12'h010, 0, -1, 0);
    commitTiming("b2b");
    drain("b2b");

    sendPkt(5, 12'h010, 0, 2, 0);
    commitTiming("gap");
    drain("gap");

    sendPkt(6, 12'h123, 0, -1, 0);
    commitTiming("fill1");
    sendPkt(6, 12'h124, 0, -1, 0);
    repeat (6) @(posedge FillClock);
    @(negedge FillClock);
    chk("fill_full", 64'(full), 64'd1);
    chk("fill_pcnt", 64'(PacketCount), 64'(expPkt));
    @(posedge FillClock); #1;
    sendPkt(6, 12'h125, 0, -1, 0);
    repeat (2) @(negedge FillClock);
    chk("drop_err", 64'(errSeen), 64'(expErr));
    chk("drop_dcnt", 64'(DropCount), 64'(expDrop));
    chk("drop_empty", 64'(BufferEmpty), 64'd0);
    chk("drop_full", 64'(full), 64'd1);
    @(posedge FillClock); #1;
    drain("fill");

    sendPkt(2, 12'h055, 0, -1, 0);
    repeat (3) @(negedge FillClock);
    chk("small_err", 64'(errSeen), 64'(expErr));
    chk("small_dcnt", 64'(DropCount), 64'(expDrop));
    chk("small_empty", 64'(BufferEmpty), 64'd1);
    chk("small_full", 64'(full), 64'd0);
    @(posedge FillClock); #1;

    sendPkt(3, 12'h0A1, 0, -1, 0);
    commitTiming("p1");
    sendPkt(3, 12'h0A2, 0, -1, 0);
    @(negedge FillClock);
    rdMode = 2;
    repeat (3) @(negedge FillClock);
    rdMode = 0;
    @(negedge FillClock);
    chk("samedge_prdy", 64'(PacketReady), 64'd1);
    chk("samedge_pcnt", 64'(PacketCount), 64'(expPkt));
    @(posedge FillClock); #1;
    drain("samedge");

    sendPkt(3, 12'h0B0, 0, -1, 0);
    commitTiming("prerst");
    sendPkt(8, 12'h0B1, 0, -1, 3);
    Reset = 1'b1;
    @(negedge FillClock);
    chk("midrst_empty", 64'(BufferEmpty), 64'd1);
    chk("midrst_prdy", 64'(PacketReady), 64'd0);
    chk("midrst_ready", 64'(DataInReady), 64'd0);
    @(posedge FillClock); #1;
    Reset = 1'b0;
    expQ.delete();
    written = popCnt;
    expPkt = 0;
    expDrop = 0;
    sendPkt(5, 12'h0B2, 0, -1, 0);
    commitTiming("postrst");
    chk("postrst_pcnt", 64'(PacketCount), 64'd1);
    drain("postrst");

    @(negedge FillClock);
    rdMode = 1;
    @(posedge FillClock); #1;
    for (int p = 0; p < 60; p++)
      sendPkt($urandom_range(1, 14), 12'($urandom), 30, -1, 0);
    repeat (8) @(posedge FillClock);
    #1;
    drain("rand");
    chk("final_pcnt", 64'(PacketCount), 64'(expPkt));
    chk("final_dcnt", 64'(DropCount), 64'(expDrop));
    chk("final_err", 64'(errSeen), 64'(expErr));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
